// File: rtl/data_mem_lsu.sv
// Load/store unit sequencing one request at a time onto a 32x16 synchronous data memory.
// Define DATA_MEM_LSU_POSTED_STORE_EN to post stores from IDLE instead of stalling in WR.
module data_mem_lsu #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              rsp_ready,
  output logic              mem_en,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_CAPT  = 3'd2,
    RESP     = 3'd3,
    WR       = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              mem_en_nxt;
  logic              mem_read_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic              rsp_valid_nxt;
  logic [DATA_W-1:0] rsp_rdata_nxt;

  // Only IDLE accepts work, so ready is a pure decode of the state register.
  assign req_ready = (state == IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The mem_* registers double as the posted-write register: a store loaded
  // here is driven to memory the following cycle, ahead of any later load.
  always_comb begin
    state_nxt     = state;
    mem_en_nxt    = 1'b0;
    mem_read_nxt  = mem_read;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    rsp_valid_nxt = rsp_valid;
    rsp_rdata_nxt = rsp_rdata;
    case (state)
      IDLE: begin
        if (req_valid) begin
          mem_en_nxt   = 1'b1;
          mem_addr_nxt = req_addr;
          if (req_we) begin
            mem_read_nxt  = 1'b0;
            mem_wdata_nxt = req_wdata;
`ifdef DATA_MEM_LSU_POSTED_STORE_EN
            state_nxt     = IDLE;
`else
            state_nxt     = WR;
`endif
          end else begin
            mem_read_nxt = 1'b1;
            state_nxt    = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: begin
        state_nxt = RD_CAPT;
      end
      RD_CAPT: begin
        rsp_valid_nxt = 1'b1;
        rsp_rdata_nxt = mem_rdata;
        state_nxt     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      WR: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_en    <= 1'b0;
      mem_read  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      mem_en    <= mem_en_nxt;
      mem_read  <= mem_read_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu: random and directed loads/stores against a
// word-array reference model; honours DATA_MEM_LSU_POSTED_STORE_EN.
module tb_data_mem_lsu;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_we;
  logic [4:0]  req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_ready = 1'b0;
  logic        mem_en;
  logic        mem_read;
  logic [4:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0;

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [15:0] data;
  } memOp_t;

  memOp_t      rdQ[$];
  memOp_t      wrQ[$];
  logic [15:0] rspQ[$];
  int          riseQ[$];

  logic [15:0] mem [32];
  logic [15:0] refMem [32];
  int          cyc = 0;
  int          assertCount = 0;
  int          failCount = 0;
  logic        randomRsp = 1'b0;
  logic        rspReadyForce = 1'b1;
  logic        loadBusy = 1'b0;
  logic        storeBusy = 1'b0;
  logic        prevValid = 1'b0;
  logic        prevTaken = 1'b0;
  logic [15:0] prevRdata = 16'h0;

`ifdef DATA_MEM_LSU_POSTED_STORE_EN
  localparam int STORE_GAP = 1;
`else
  localparam int STORE_GAP = 2;
`endif

  data_mem_lsu #(.DATA_W(16), .ADDR_W(5)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_ready (rsp_ready),
    .mem_en    (mem_en),
    .mem_read  (mem_read),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous memory: read data appears the cycle after the read edge.
  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]    = 16'(i);
      refMem[i] = 16'(i);
    end
  end

  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_read) mem_rdata <= mem[mem_addr];
      else          mem[mem_addr] <= mem_wdata;
    end
  end

  always @(posedge clock) begin
    #1;
    rsp_ready = randomRsp ? 1'($urandom_range(0, 1)) : rspReadyForce;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Monitor: the request side pushes model expectations, the memory and
  // response sides pop and compare whatever the DUT presents.
  always @(negedge clock) begin
    memOp_t e;
    logic   taken;
    if (!reset_n) begin
      rdQ.delete();
      wrQ.delete();
      rspQ.delete();
      riseQ.delete();
      loadBusy  = 1'b0;
      storeBusy = 1'b0;
      prevValid = 1'b0;
      prevTaken = 1'b0;
      prevRdata = rsp_rdata;
    end else begin
      checkOutput("req_ready", 32'(req_ready), 32'(!(loadBusy || storeBusy)));
      storeBusy = 1'b0;

      if (mem_en) begin
        if (mem_read) begin
          if (rdQ.size() == 0) checkOutput("unexpected_read", 32'(mem_en), 32'd0);
          else begin
            e = rdQ.pop_front();
            checkOutput("read_addr", 32'(mem_addr), 32'(e.addr));
            checkOutput("read_cycle", 32'(cyc), 32'(e.cyc));
          end
        end else begin
          if (wrQ.size() == 0) checkOutput("unexpected_write", 32'(mem_en), 32'd0);
          else begin
            e = wrQ.pop_front();
            checkOutput("write_addr", 32'(mem_addr), 32'(e.addr));
            checkOutput("write_data", 32'(mem_wdata), 32'(e.data));
            checkOutput("write_cycle", 32'(cyc), 32'(e.cyc));
          end
        end
      end else begin
        if (rdQ.size() > 0 && rdQ[0].cyc <= cyc) begin
          checkOutput("read_missing", 32'(mem_en), 32'd1);
          void'(rdQ.pop_front());
        end
        if (wrQ.size() > 0 && wrQ[0].cyc <= cyc) begin
          checkOutput("write_missing", 32'(mem_en), 32'd1);
          void'(wrQ.pop_front());
        end
      end

      if (rsp_valid && !prevValid) begin
        if (riseQ.size() == 0) checkOutput("unexpected_rsp", 32'(rsp_valid), 32'd0);
        else checkOutput("rsp_latency", 32'(cyc), 32'(riseQ.pop_front()));
      end
      if (rsp_valid && prevValid && !prevTaken) checkOutput("rsp_hold", 32'(rsp_rdata), 32'(prevRdata));
      if (!rsp_valid && prevValid) checkOutput("rsp_keep", 32'(rsp_rdata), 32'(prevRdata));

      taken = rsp_valid && rsp_ready;
      if (taken) begin
        if (rspQ.size() == 0) checkOutput("rsp_extra", 32'(rsp_valid), 32'd0);
        else checkOutput("rsp_data", 32'(rsp_rdata), 32'(rspQ.pop_front()));
        loadBusy = 1'b0;
      end

      if (req_valid && req_ready) begin
        e.cyc  = cyc + 1;
        e.addr = req_addr;
        if (req_we) begin
          e.data = req_wdata;
          refMem[req_addr] = req_wdata;
          wrQ.push_back(e);
`ifndef DATA_MEM_LSU_POSTED_STORE_EN
          storeBusy = 1'b1;
`endif
        end else begin
          e.data = 16'h0;
          rdQ.push_back(e);
          rspQ.push_back(refMem[req_addr]);
          riseQ.push_back(cyc + 3);
          loadBusy = 1'b1;
        end
      end

      prevValid = rsp_valid;
      prevRdata = rsp_rdata;
      prevTaken = taken;
    end
  end

  // Presents a request and returns just after the edge that accepted it,
  // leaving req_valid high so the caller can chain back-to-back requests.
  task automatic applyStimulus(input logic we, input logic [4:0] addr, input logic [15:0] data,
                               output int acceptCyc);
    logic done;
    done      = 1'b0;
    acceptCyc = -1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clock);
      if (req_ready) begin
        done      = 1'b1;
        acceptCyc = cyc;
      end
      @(posedge clock);
      #1;
    end
    if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic dropRequest();
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic waitIdle();
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(negedge clock);
      if (req_ready && !rsp_valid && !mem_en && rspQ.size() == 0) idle = 1'b1;
    end
    if (!idle) checkOutput("idle_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int c0, c1, c2, c3;
    logic waitOk;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 5'd0;
    req_wdata = 16'h0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_mem_en", 32'(mem_en), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    $display("[TB] load addr 5");
    applyStimulus(1'b0, 5'd5, 16'h0, c0);
    dropRequest();
    waitIdle();

    $display("[TB] reset during RD_CAPT");
    applyStimulus(1'b0, 5'd9, 16'h0, c0);
    dropRequest();
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midreset_mem_en", 32'(mem_en), 32'd0);
    checkOutput("midreset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("midreset_mem_addr", 32'(mem_addr), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    waitIdle();

    $display("[TB] store BEEF to 31 then load 31");
    applyStimulus(1'b1, 5'd31, 16'hBEEF, c0);
    applyStimulus(1'b0, 5'd31, 16'h0, c1);
    dropRequest();
    waitIdle();

    $display("[TB] load addr 0 with held response");
    rspReadyForce = 1'b0;
    applyStimulus(1'b0, 5'd0, 16'h0, c0);
    dropRequest();
    waitOk = 1'b0;
    for (int i = 0; i < 20 && !waitOk; i++) begin
      @(negedge clock);
      if (rsp_valid) waitOk = 1'b1;
    end
    if (!waitOk) checkOutput("rsp_timeout", 32'd0, 32'd1);
    repeat (5) @(posedge clock);
    rspReadyForce = 1'b1;
    waitIdle();

    $display("[TB] three back-to-back stores");
    applyStimulus(1'b1, 5'd1, 16'h1111, c1);
    applyStimulus(1'b1, 5'd2, 16'h2222, c2);
    applyStimulus(1'b1, 5'd3, 16'h3333, c3);
    checkOutput("store_gap_1", 32'(c2 - c1), 32'(STORE_GAP));
    checkOutput("store_gap_2", 32'(c3 - c2), 32'(STORE_GAP));

    $display("[TB] store 1234 to 7 then load 7 back-to-back");
    applyStimulus(1'b1, 5'd7, 16'h1234, c0);
    applyStimulus(1'b0, 5'd7, 16'h0, c1);
    dropRequest();
    waitIdle();
    applyStimulus(1'b0, 5'd1, 16'h0, c0);
    applyStimulus(1'b0, 5'd3, 16'h0, c0);
    dropRequest();
    waitIdle();

    $display("[TB] random traffic");
    randomRsp = 1'b1;
    for (int n = 0; n < 200; n++) begin
      logic [4:0] a;
      if ($urandom_range(0, 3) == 0) begin
        dropRequest();
        repeat ($urandom_range(1, 2)) @(posedge clock);
        #1;
      end
      a = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      applyStimulus(1'($urandom_range(0, 1)), a, 16'($urandom), c0);
    end
    dropRequest();
    randomRsp     = 1'b0;
    rspReadyForce = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    waitIdle();
    checkOutput("drain_rsp", 32'(rspQ.size()), 32'd0);
    checkOutput("drain_wr", 32'(wrQ.size()), 32'd0);
    checkOutput("drain_rd", 32'(rdQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
